if_id_hazard_stage: RTL and testbench
=====================================

Name: if_id_hazard_stage

Overview:
- IF/ID pipeline register with an integrated hazard controller. It sits directly upstream of the ID/EX register.
- Captures the fetched PC+4 and instruction, and detects load-use hazards against the instruction currently in EX.
- Freezes the PC and IF/ID on a hazard, and injects a zero-control bubble into ID/EX.
- Squashes wrong-path instructions when the EX stage reports a taken branch. Keeps saturating stall/flush counters.

Parameters:
- FLUSH_CYCLES, 1, number of cycles IF/ID is held invalid after branch_taken (1..7).
- CNT_W, 16, width of the stall_cnt and flush_cnt performance counters.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- IF_PC4  input  32  PC+4 from fetch.
- IF_instr  input  32  instruction word from instruction memory.
- imem_ready  input  1  instruction word is valid this cycle.
- branch_taken  input  1  taken branch resolved in EX; PC target is handled externally.
- ctrl_decoded  input  11  control word decoded from ID_instr, layout {RegDst, Branch[1:0], MemRead, MemtoReg, ALUop[2:0], MemWrite, ALUSrc, RegWrite}.
- EX_control_words  input  11  control word currently in EX; bit 7 is MemRead.
- EX_rs_rt_rd  input  15  {rs[14:10], rt[9:5], rd[4:0]} of the EX instruction.
- ID_PC4  output  32  registered PC+4.
- ID_instr  output  32  registered instruction.
- ID_valid  output  1  ID instruction is live.
- ID_control_words  output  11  control word to ID/EX; forced to 0 on a bubble.
- pc_write_en  output  1  PC update enable.
- hazard_stall  output  1  load-use stall this cycle.
- stall_cnt  output  CNT_W  saturating count of load-use stall cycles.
- flush_cnt  output  CNT_W  saturating count of branch flushes.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - Registered outputs: ID_PC4=0, ID_instr=0, ID_valid=0, stall_cnt=0, flush_cnt=0; state=RUN; flush counter=0.
  - While rst_n=0: pc_write_en=0, hazard_stall=0, ID_control_words=0.
  - Reset mid-stall or mid-flush returns to RUN with no residue.
- Field extraction: ID_rs=ID_instr[25:21], ID_rt=ID_instr[20:16], EX_rt=EX_rs_rt_rd[9:5].
- load_use (combinational) = EX_control_words[7] & ID_valid & (EX_rt!=0) & (EX_rt==ID_rs | EX_rt==ID_rt).
- FSM states RUN, FLUSH. Per-cycle priority, highest first: reset, branch_taken, load_use, !imem_ready, normal.
  - branch_taken (any state):
    - Next edge: ID_instr<=0, ID_valid<=0, ID_PC4<=0.
    - Then: state<=FLUSH, flush counter<=FLUSH_CYCLES-1, flush_cnt+1 (saturating).
    - That same cycle: ID_control_words=0 and pc_write_en=1.
  - FLUSH state:
    - IF/ID is loaded with zero/invalid and pc_write_en=1; the counter decrements.
    - At 0, return to RUN on the next edge.
    - With FLUSH_CYCLES=1, FLUSH lasts zero cycles and the state goes directly to RUN.
  - load_use (RUN only):
    - IF/ID holds its value; pc_write_en=0; hazard_stall=1; ID_control_words=0; stall_cnt+1 (saturating).
    - Next cycle the EX control word is the bubble, so the stall is exactly 1 cycle.
  - !imem_ready (RUN, no hazard):
    - IF/ID is loaded with instr=0, ID_valid=0; pc_write_en=0.
    - ID_control_words = ID_valid ? ctrl_decoded : 0.
  - Normal: IF/ID<=IF_PC4/IF_instr, ID_valid<=1, pc_write_en=1, ID_control_words = ID_valid ? ctrl_decoded : 0.
- ID_control_words is always 0 when ID_valid=0.
- Counters saturate at all-ones and do not wrap.
- branch_taken together with load_use: the flush wins, no stall is counted, and hazard_stall=0.

Test Plan:
- Reset with rst_n=0 for 2 cycles while driving IF_instr=32'hFFFFFFFF -> all outputs 0; after release, the first edge gives ID_valid=1 and ID_instr=32'hFFFFFFFF.
- Load-use: EX_control_words=11'h080, EX_rs_rt_rd rt=5'd8, ID_instr=32'h01095020 (add, rs=8) -> hazard_stall=1, pc_write_en=0, ID_control_words=0, ID_instr held; stall_cnt=1. Next cycle, with EX_control_words=0, pipeline advances.
- EX_rt=0 with MemRead=1 and ID_rs=0 -> no stall.
- branch_taken=1 with FLUSH_CYCLES=3 -> ID_valid=0 for 3 consecutive cycles, then resumes; flush_cnt=1; ID_control_words=0 throughout.
- branch_taken and load_use in the same cycle -> no stall, pc_write_en=1, stall_cnt unchanged, flush_cnt+1.
- imem_ready=0 for 2 cycles -> pc_write_en=0 and ID_valid=0 for 2 cycles. Counter saturation with CNT_W=2: 5 load-use stalls -> stall_cnt=3.

Source files
------------

// File: rtl/if_id_hazard_stage.sv
// IF/ID pipeline register with load-use hazard detection, branch squash,
// bubble injection toward ID/EX and saturating stall/flush counters.
module if_id_hazard_stage #(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      IF_PC4,
  input  logic [31:0]      IF_instr,
  input  logic             imem_ready,
  input  logic             branch_taken,
  input  logic [10:0]      ctrl_decoded,
  input  logic [10:0]      EX_control_words,
  input  logic [14:0]      EX_rs_rt_rd,
  output logic [31:0]      ID_PC4,
  output logic [31:0]      ID_instr,
  output logic             ID_valid,
  output logic [10:0]      ID_control_words,
  output logic             pc_write_en,
  output logic             hazard_stall,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic {ST_RUN, ST_FLUSH} state_t;
  typedef enum logic [1:0] {IFID_HOLD, IFID_LOAD, IFID_CLEAR} ifid_op_t;

  localparam logic [2:0]       FLUSH_INIT = 3'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           r_state;
  state_t           w_nextState;
  ifid_op_t         w_ifidOp;
  logic [2:0]       r_flushLeft;
  logic [2:0]       w_flushLeftNext;
  logic [31:0]      r_pc4;
  logic [31:0]      r_instr;
  logic             r_valid;
  logic [CNT_W-1:0] r_stallCnt;
  logic [CNT_W-1:0] r_flushCnt;
  logic             w_stallInc;
  logic             w_flushInc;
  logic [4:0]       w_idRs;
  logic [4:0]       w_idRt;
  logic [4:0]       w_exRt;
  logic             w_loadUse;
  logic             w_unused;

  assign w_idRs    = r_instr[25:21];
  assign w_idRt    = r_instr[20:16];
  assign w_exRt    = EX_rs_rt_rd[9:5];
  assign w_loadUse = EX_control_words[7] & r_valid & (w_exRt != 5'd0) &
                     ((w_exRt == w_idRs) | (w_exRt == w_idRt));
  assign w_unused  = ^{EX_control_words[10:8], EX_control_words[6:0],
                       EX_rs_rt_rd[14:10], EX_rs_rt_rd[4:0]};

  assign ID_PC4    = r_pc4;
  assign ID_instr  = r_instr;
  assign ID_valid  = r_valid;
  assign stall_cnt = r_stallCnt;
  assign flush_cnt = r_flushCnt;

  // Branch squash outranks the load-use stall, so a hazard on a wrong-path
  // instruction never freezes the PC or bumps the stall counter.
  always_comb begin
    w_nextState      = r_state;
    w_flushLeftNext  = r_flushLeft;
    w_ifidOp         = IFID_HOLD;
    pc_write_en      = 1'b0;
    hazard_stall     = 1'b0;
    ID_control_words = 11'd0;
    w_stallInc       = 1'b0;
    w_flushInc       = 1'b0;
    if (!rst_n) begin
      w_nextState     = ST_RUN;
      w_flushLeftNext = 3'd0;
    end else if (branch_taken) begin
      w_ifidOp    = IFID_CLEAR;
      pc_write_en = 1'b1;
      w_flushInc  = 1'b1;
      if (FLUSH_INIT != 3'd0) begin
        w_nextState     = ST_FLUSH;
        w_flushLeftNext = FLUSH_INIT;
      end else begin
        w_nextState     = ST_RUN;
        w_flushLeftNext = 3'd0;
      end
    end else if (r_state == ST_FLUSH) begin
      w_ifidOp        = IFID_CLEAR;
      pc_write_en     = 1'b1;
      w_flushLeftNext = r_flushLeft - 3'd1;
      if (r_flushLeft <= 3'd1) begin
        w_nextState = ST_RUN;
      end
    end else if (w_loadUse) begin
      w_ifidOp     = IFID_HOLD;
      hazard_stall = 1'b1;
      w_stallInc   = 1'b1;
    end else begin
      ID_control_words = r_valid ? ctrl_decoded : 11'd0;
      if (imem_ready) begin
        w_ifidOp    = IFID_LOAD;
        pc_write_en = 1'b1;
      end else begin
        w_ifidOp = IFID_CLEAR;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_RUN;
      r_flushLeft <= 3'd0;
      r_pc4       <= 32'd0;
      r_instr     <= 32'd0;
      r_valid     <= 1'b0;
      r_stallCnt  <= '0;
      r_flushCnt  <= '0;
    end else begin
      r_state     <= w_nextState;
      r_flushLeft <= w_flushLeftNext;
      case (w_ifidOp)
        IFID_LOAD: begin
          r_pc4   <= IF_PC4;
          r_instr <= IF_instr;
          r_valid <= 1'b1;
        end
        IFID_CLEAR: begin
          r_pc4   <= 32'd0;
          r_instr <= 32'd0;
          r_valid <= 1'b0;
        end
        default: begin
          r_pc4   <= r_pc4;
          r_instr <= r_instr;
          r_valid <= r_valid;
        end
      endcase
      // Performance counters stick at all-ones instead of wrapping.
      if (w_stallInc && (r_stallCnt != '1)) begin
        r_stallCnt <= r_stallCnt + CNT_ONE;
      end
      if (w_flushInc && (r_flushCnt != '1)) begin
        r_flushCnt <= r_flushCnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_if_id_hazard_stage.sv
// Scoreboard bench for if_id_hazard_stage: directed test-plan cases followed
// by random traffic, checked against a cycle-level behavioural model.
module tb_if_id_hazard_stage;

  localparam int FLUSH_CYCLES = 3;
  localparam int CNT_W        = 2;
  localparam int CNT_MAX      = (1 << CNT_W) - 1;

  typedef struct {
    logic [31:0]      pc4;
    logic [31:0]      instr;
    logic             valid;
    logic [10:0]      ctrl;
    logic             pcw;
    logic             hs;
    logic [CNT_W-1:0] sc;
    logic [CNT_W-1:0] fc;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic [31:0]      IF_PC4;
  logic [31:0]      IF_instr;
  logic             imem_ready;
  logic             branch_taken;
  logic [10:0]      ctrl_decoded;
  logic [10:0]      EX_control_words;
  logic [14:0]      EX_rs_rt_rd;
  logic [31:0]      ID_PC4;
  logic [31:0]      ID_instr;
  logic             ID_valid;
  logic [10:0]      ID_control_words;
  logic             pc_write_en;
  logic             hazard_stall;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  exp_t scoreQ[$];
  exp_t monExp;
  int   compared   = 0;
  int   mismatched = 0;

  // Model state: what IF/ID should hold, counters, and flush cycles still owed.
  logic [31:0] mPc4;
  logic [31:0] mInstr;
  logic        mValid;
  int          mStallCnt;
  int          mFlushCnt;
  int          mFlushRemaining;

  if_id_hazard_stage #(.FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .IF_PC4(IF_PC4), .IF_instr(IF_instr),
    .imem_ready(imem_ready), .branch_taken(branch_taken),
    .ctrl_decoded(ctrl_decoded), .EX_control_words(EX_control_words),
    .EX_rs_rt_rd(EX_rs_rt_rd), .ID_PC4(ID_PC4), .ID_instr(ID_instr),
    .ID_valid(ID_valid), .ID_control_words(ID_control_words),
    .pc_write_en(pc_write_en), .hazard_stall(hazard_stall),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one cycle of inputs, predicts the observable outputs for that
  // cycle, queues them, then advances the model across the clock edge.
  task automatic applyStimulus(input logic rst, input logic [31:0] pc4, input logic [31:0] instr,
                               input logic ready, input logic br, input logic [10:0] dec,
                               input logic [10:0] exCtrl, input logic [14:0] exRegs);
    exp_t       e;
    logic [4:0] exRt;
    bit         loadUse;
    rst_n = rst; IF_PC4 = pc4; IF_instr = instr; imem_ready = ready;
    branch_taken = br; ctrl_decoded = dec; EX_control_words = exCtrl; EX_rs_rt_rd = exRegs;
    e.pc4 = mPc4; e.instr = mInstr; e.valid = mValid;
    e.sc = CNT_W'(mStallCnt); e.fc = CNT_W'(mFlushCnt);
    e.pcw = 1'b0; e.hs = 1'b0; e.ctrl = 11'd0;
    exRt = exRegs[9:5];
    loadUse = exCtrl[7] && mValid && (exRt != 5'd0) &&
              ((exRt == mInstr[25:21]) || (exRt == mInstr[20:16]));
    if (!rst) begin
      mPc4 = 0; mInstr = 0; mValid = 0;
      mStallCnt = 0; mFlushCnt = 0; mFlushRemaining = 0;
    end else if (br) begin
      e.pcw = 1'b1;
      mPc4 = 0; mInstr = 0; mValid = 0;
      if (mFlushCnt < CNT_MAX) mFlushCnt++;
      mFlushRemaining = FLUSH_CYCLES - 1;
    end else if (mFlushRemaining > 0) begin
      e.pcw = 1'b1;
      mPc4 = 0; mInstr = 0; mValid = 0;
      mFlushRemaining--;
    end else if (loadUse) begin
      e.hs = 1'b1;
      if (mStallCnt < CNT_MAX) mStallCnt++;
    end else begin
      e.ctrl = mValid ? dec : 11'd0;
      if (ready) begin
        e.pcw = 1'b1;
        mPc4 = pc4; mInstr = instr; mValid = 1'b1;
      end else begin
        mPc4 = 0; mInstr = 0; mValid = 0;
      end
    end
    scoreQ.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: every falling edge, compare the DUT against the oldest prediction.
  always @(negedge clk) begin
    if (scoreQ.size() != 0) begin
      monExp = scoreQ.pop_front();
      checkOutput("ID_PC4", ID_PC4, monExp.pc4);
      checkOutput("ID_instr", ID_instr, monExp.instr);
      checkOutput("ID_valid", 32'(ID_valid), 32'(monExp.valid));
      checkOutput("ID_control_words", 32'(ID_control_words), 32'(monExp.ctrl));
      checkOutput("pc_write_en", 32'(pc_write_en), 32'(monExp.pcw));
      checkOutput("hazard_stall", 32'(hazard_stall), 32'(monExp.hs));
      checkOutput("stall_cnt", 32'(stall_cnt), 32'(monExp.sc));
      checkOutput("flush_cnt", 32'(flush_cnt), 32'(monExp.fc));
    end
  end

  initial begin
    logic [10:0] exCtrl;
    logic [4:0]  rt;
    int          drain;
    rst_n = 1'b0; IF_PC4 = 32'd0; IF_instr = 32'hFFFFFFFF; imem_ready = 1'b1;
    branch_taken = 1'b0; ctrl_decoded = 11'h5A3; EX_control_words = 11'd0; EX_rs_rt_rd = 15'd0;
    mPc4 = 0; mInstr = 0; mValid = 0; mStallCnt = 0; mFlushCnt = 0; mFlushRemaining = 0;
    @(posedge clk);
    #1;
    // Second reset cycle with an all-ones fetch word, then release.
    applyStimulus(1'b0, 32'h4, 32'hFFFFFFFF, 1'b1, 1'b0, 11'h5A3, 11'h080, 15'h7FFF);
    applyStimulus(1'b1, 32'h4, 32'hFFFFFFFF, 1'b1, 1'b0, 11'h5A3, 11'd0, 15'd0);
    // Load-use on the add, then advance once EX holds the bubble.
    applyStimulus(1'b1, 32'h8, 32'h01095020, 1'b1, 1'b0, 11'h3C1, 11'd0, 15'd0);
    applyStimulus(1'b1, 32'hC, 32'h8C080000, 1'b1, 1'b0, 11'h2B5, 11'h080, {5'd0, 5'd8, 5'd0});
    applyStimulus(1'b1, 32'hC, 32'h8C080000, 1'b1, 1'b0, 11'h2B5, 11'd0, 15'd0);
    // EX_rt = 0 with rs = 0 must not stall.
    applyStimulus(1'b1, 32'h10, 32'h00004020, 1'b1, 1'b0, 11'h111, 11'd0, 15'd0);
    applyStimulus(1'b1, 32'h14, 32'h01095020, 1'b1, 1'b0, 11'h222, 11'h080, {5'd0, 5'd0, 5'd0});
    // Branch coinciding with a load-use hazard, then the flush window.
    applyStimulus(1'b1, 32'h18, 32'h12345678, 1'b1, 1'b1, 11'h333, 11'h080, {5'd0, 5'd8, 5'd0});
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b1, 32'h100 + 32'(4 * i), 32'h00A0B000 + 32'(i), 1'b1, 1'b0, 11'h4C4, 11'd0, 15'd0);
    // Instruction memory not ready for two cycles.
    applyStimulus(1'b1, 32'h200, 32'hDEADBEEF, 1'b0, 1'b0, 11'h155, 11'd0, 15'd0);
    applyStimulus(1'b1, 32'h200, 32'hDEADBEEF, 1'b0, 1'b0, 11'h155, 11'd0, 15'd0);
    applyStimulus(1'b1, 32'h204, 32'h01095020, 1'b1, 1'b0, 11'h2AA, 11'd0, 15'd0);
    // Five consecutive stalls push the 2-bit counter to saturation.
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b1, 32'h208, 32'h0, 1'b1, 1'b0, 11'h2AA, 11'h080, {5'd3, 5'd8, 5'd1});
    applyStimulus(1'b1, 32'h208, 32'h0, 1'b1, 1'b0, 11'h2AA, 11'd0, 15'd0);
    // Random traffic, biased toward hazards against the live ID instruction.
    for (int i = 0; i < 400; i++) begin
      exCtrl = 11'($urandom);
      exCtrl[7] = ($urandom_range(0, 1) == 1);
      case ($urandom_range(0, 2))
        0:       rt = mInstr[25:21];
        1:       rt = mInstr[20:16];
        default: rt = 5'($urandom);
      endcase
      applyStimulus(($urandom_range(0, 39) != 0), $urandom, $urandom,
                    ($urandom_range(0, 6) != 0), ($urandom_range(0, 7) == 0),
                    11'($urandom), exCtrl, {5'($urandom), rt, 5'($urandom)});
    end
    drain = 0;
    while ((scoreQ.size() != 0) && (drain < 10)) begin
      @(negedge clk);
      drain++;
    end
    if (scoreQ.size() != 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", scoreQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
